// File: rtl/sfixed_vec_pkg.sv
// sfixed_vec_pkg: shared widths, operand/response types and width helper for the sfixed vector multiply arbiter
package sfixed_vec_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_A_LEFT = 3;
  localparam int DEF_A_RIGHT = 4;
  localparam int DEF_B_LEFT = 3;
  localparam int DEF_B_RIGHT = 4;
  localparam int DEF_OUT_LEFT = 7;
  localparam int DEF_OUT_RIGHT = 8;
  function automatic int fw(int l, int r);
    return l + r + 1;
  endfunction
  localparam int A_W = fw(DEF_A_LEFT, DEF_A_RIGHT);
  localparam int B_W = fw(DEF_B_LEFT, DEF_B_RIGHT);
  localparam int OUT_W = fw(DEF_OUT_LEFT, DEF_OUT_RIGHT);
  localparam int ID_W = $clog2(DEF_N_REQ);
  typedef logic [2:0][A_W-1:0] vec_a_t;
  typedef logic [2:0][B_W-1:0] vec_b_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OUT_W-1:0] x;
    logic [OUT_W-1:0] y;
    logic [OUT_W-1:0] z;
  } rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, first request at or after ptr wins, ptr moves past the winner on grant
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input logic clk,
  input logic rst,
  input logic [N_REQ-1:0] req,
  input logic en,
  output logic [N_REQ-1:0] grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, k;
  logic fire;
  always_comb begin
    grant_idx = '0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      grant_idx = req[k] ? k : grant_idx;
    end
  end
  assign fire = en && |req;
  assign grant = fire ? N_REQ'(1) << grant_idx : '0;
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (fire) ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/sfixed_mult_independent_9x9.sv
// sfixed_mult_independent_9x9: three independent signed 9x9 fixed-point multiplies with truncating, wrapping rescale
module sfixed_mult_independent_9x9 #(
  parameter int A_LEFT = 3,
  parameter int A_RIGHT = 4,
  parameter int B_LEFT = 3,
  parameter int B_RIGHT = 4,
  parameter int OUT_LEFT = 7,
  parameter int OUT_RIGHT = 8
) (
  input logic [3*(A_LEFT+A_RIGHT+1)-1:0] a,
  input logic [3*(B_LEFT+B_RIGHT+1)-1:0] b,
  output logic [3*(OUT_LEFT+OUT_RIGHT+1)-1:0] p
);
  localparam int AW = A_LEFT + A_RIGHT + 1;
  localparam int BW = B_LEFT + B_RIGHT + 1;
  localparam int OW = OUT_LEFT + OUT_RIGHT + 1;
  localparam int LSB = A_RIGHT + B_RIGHT - OUT_RIGHT;
  if (AW > 9 || BW > 9 || OUT_RIGHT > A_RIGHT + B_RIGHT || A_RIGHT + B_RIGHT + OUT_LEFT > 17) begin : g_bad
    $error("sfixed_mult_independent_9x9: illegal fixed-point format");
  end
  for (genvar i = 0; i < 3; i++) begin : g_lane
    logic signed [8:0] sa, sb;
    logic signed [17:0] pr;
    logic unused_pr;
    assign sa = 9'($signed(a[i*AW +: AW]));
    assign sb = 9'($signed(b[i*BW +: BW]));
    assign pr = sa * sb;
    assign unused_pr = ^pr;
    assign p[i*OW +: OW] = pr[LSB +: OW];
  end
endmodule

// File: rtl/sfixed_vec_mult_arbiter.sv
// sfixed_vec_mult_arbiter: round-robin sharing of one 3-lane signed fixed-point multiplier with a 2-stage tagged pipeline
module sfixed_vec_mult_arbiter import sfixed_vec_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int A_LEFT = DEF_A_LEFT,
  parameter int A_RIGHT = DEF_A_RIGHT,
  parameter int B_LEFT = DEF_B_LEFT,
  parameter int B_RIGHT = DEF_B_RIGHT,
  parameter int OUT_LEFT = DEF_OUT_LEFT,
  parameter int OUT_RIGHT = DEF_OUT_RIGHT
) (
  input logic clk,
  input logic rst,
  input logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input logic [N_REQ*3*fw(A_LEFT, A_RIGHT)-1:0] req_a,
  input logic [N_REQ*3*fw(B_LEFT, B_RIGHT)-1:0] req_b,
  output logic rsp_valid,
  input logic rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [fw(OUT_LEFT, OUT_RIGHT)-1:0] rsp_x,
  output logic [fw(OUT_LEFT, OUT_RIGHT)-1:0] rsp_y,
  output logic [fw(OUT_LEFT, OUT_RIGHT)-1:0] rsp_z,
  output logic busy
);
  localparam int AW = fw(A_LEFT, A_RIGHT);
  localparam int BW = fw(B_LEFT, B_RIGHT);
  localparam int OW = fw(OUT_LEFT, OUT_RIGHT);
  localparam int IW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad
    $error("sfixed_vec_mult_arbiter: N_REQ must be 2..8");
  end
  logic s1_v, s2_v, s1_adv, s2_adv, accept;
  logic [IW-1:0] s1_id, g_idx;
  logic [3*AW-1:0] s1_a;
  logic [3*BW-1:0] s1_b;
  logic [3*OW-1:0] prod;
  assign s2_adv = !s2_v || (rsp_valid && rsp_ready);
  assign s1_adv = !s1_v || s2_adv;
  assign accept = |req_ready;
  assign rsp_valid = s2_v;
  assign busy = s1_v || s2_v;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(s1_adv && !rst),
    .grant(req_ready),
    .grant_idx(g_idx)
  );
  sfixed_mult_independent_9x9 #(
    .A_LEFT(A_LEFT),
    .A_RIGHT(A_RIGHT),
    .B_LEFT(B_LEFT),
    .B_RIGHT(B_RIGHT),
    .OUT_LEFT(OUT_LEFT),
    .OUT_RIGHT(OUT_RIGHT)
  ) u_mul (
    .a(s1_a),
    .b(s1_b),
    .p(prod)
  );
  always_ff @(posedge clk)
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_id <= '0;
      s1_a <= '0;
      s1_b <= '0;
      rsp_id <= '0;
      rsp_x <= '0;
      rsp_y <= '0;
      rsp_z <= '0;
    end else begin
      if (s1_adv) s1_v <= accept;
      if (accept) begin
        s1_id <= g_idx;
        s1_a <= req_a[int'(g_idx)*3*AW +: 3*AW];
        s1_b <= req_b[int'(g_idx)*3*BW +: 3*BW];
      end
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        rsp_id <= s1_id;
        rsp_x <= prod[0 +: OW];
        rsp_y <= prod[OW +: OW];
        rsp_z <= prod[2*OW +: OW];
      end
    end
endmodule

// File: doc/sfixed_vec_mult_arbiter.md
Name: sfixed_vec_mult_arbiter

Overview:
- Shares one 3-lane signed fixed-point multiplier (sfixed_mult_independent_9x9) among N_REQ requesters.
- Each requester offers a 3-component operand pair (x,y,z) under a valid/ready handshake.
- Round-robin grant; operands are registered, multiplied, and the result registered, then returned on one tagged response port with backpressure.
- Sits between the vector-ops issue logic and any consumer that needs per-lane products.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- A_LEFT, 3, integer bits of operand A (excluding sign).
- A_RIGHT, 4, fraction bits of operand A.
- B_LEFT, 3, integer bits of operand B.
- B_RIGHT, 4, fraction bits of operand B.
- OUT_LEFT, 7, integer bits of result.
- OUT_RIGHT, 8, fraction bits of result.
- Legal range: A_W=A_LEFT+A_RIGHT+1 ≤ 9, B_W ≤ 9, OUT_RIGHT ≤ A_RIGHT+B_RIGHT, A_RIGHT+B_RIGHT+OUT_LEFT ≤ 17. Elaboration fails otherwise.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*3*A_W  packed operand A, per requester {z,y,x}.
- req_b  in  N_REQ*3*B_W  packed operand B, per requester {z,y,x}.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  $clog2(N_REQ)  index of the requester that issued the result.
- rsp_x, rsp_y, rsp_z  out  OUT_W each  signed products, OUT_W=OUT_LEFT+OUT_RIGHT+1.
- busy  out  1  high while any transaction is in flight.

Behaviour:
- Reset: rsp_valid=0, rsp_id=0, rsp_x/y/z=0, busy=0, req_ready=0, stage valids cleared, RR pointer=0 (req 0 highest priority). Reset mid-operation silently drops in-flight transactions.
- Pipeline: S1 is the operand register (id, a, b), feeding the multiplier combinationally. S2 is the result register (id, x, y, z), which drives rsp_*.
- Stage advance: s2_adv = !s2_v | (rsp_valid & rsp_ready); s1_adv = !s1_v | s2_adv.
- Grant: when s1_adv, choose the first valid requester at or after ptr, wrapping modulo N_REQ. req_ready[g]=1 that cycle and is combinational on req_valid. Requesters must not make valid depend on ready.
- Accepted request (req_valid[g] & req_ready[g]): load S1, ptr <= (g+1) mod N_REQ. No accept leaves ptr unchanged.
- Latency: accept at edge N puts the result on rsp_* after edge N+1 (2 cycles accept to rsp_valid). Throughput is 1/cycle while rsp_ready=1.
- Backpressure: with rsp_valid & !rsp_ready, S2 holds and its outputs stay stable. S1 holds if full, and no grant is issued if S1 is full. Max 2 in flight.
- Simultaneous events: a response fire and a new grant in the same cycle is allowed (full pipeline shift).
- Arithmetic: operands are sign-extended to 9 bits and form an 18-bit signed product. Output is product bits [A_RIGHT+B_RIGHT+OUT_LEFT : A_RIGHT+B_RIGHT-OUT_RIGHT]. This is truncation toward -inf with wrap on overflow; no saturation or rounding.
- busy = s1_v | s2_v.
- Ordering: responses return in acceptance order.
- Fairness: a continuously-valid requester is granted within N_REQ accepts.

Decomposition:
- Package sfixed_vec_pkg:
  - width localparams A_W, B_W, OUT_W, ID_W;
  - typedefs vec_a_t and vec_b_t (3-element packed arrays);
  - typedef rsp_t (id, x, y, z).
- Sub-module rr_arbiter (N_REQ): inputs req, en; outputs grant one-hot, grant_idx; internal ptr with update on en&|req.
- Multiplier: instantiate the existing 3-lane multiplier with the pass-through parameters.

Test Plan:
- Basic product: req0 a={0x10,0x10,0x10} (1.0), b={0x28,0x20,0xF0} (2.5, 2.0, -1.0), rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_x=0x0280, rsp_y=0x0200, rsp_z=0xFF00.
- Negative operands: a_x=0xE8 (-1.5), b_x=0x20 (2.0) -> rsp_x=0xFD00 (-3.0). a_y=0x80 (-8.0), b_y=0x80 (-8.0) -> rsp_y=0x4000 (64.0).
- Round-robin: all 4 requesters hold valid continuously -> grant order 0,1,2,3,0,1. Each req_ready is high exactly once per 4 cycles; rsp_id follows the same order.
- Backpressure: hold rsp_ready=0 for 5 cycles with req0 valid -> exactly 2 accepts, then req_ready=0 and rsp_* stable. Release -> results drain in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 2 in flight -> next cycle rsp_valid=0, busy=0, ptr=0. A subsequent request from req2 and req0 together grants req0 first.
- Sparse: single req3 pulse -> ptr becomes 0 after accept. busy is high for exactly 2 cycles when rsp_ready=1.
